fp_add_pipe: RTL

- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. It is the successor to the combinational FP16 adder in the MAC datapath.
- Generalised over exponent and mantissa width. Adds a valid/ready handshake, a 3-stage pipeline, an add/subtract mode, full normalisation after cancellation (leading-zero count), round-to-nearest-even, Inf/NaN handling and status flags.
- Sits between the multiplier output and the accumulator register of the MAC.

---
 rtl/fp_add_pipe.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined floating-point adder/subtractor with valid/ready handshake.
// Define FP_ADD_RNE_EN for round-to-nearest-even; when undefined, results truncate toward zero.
module fp_add_pipe #(
   parameter  int EXP_W = 5,
   parameter  int MAN_W = 10,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic [3:0]   flags
);

   localparam int FW    = MAN_W + 4;            // hidden + fraction + guard/round/sticky
   localparam int SW    = MAN_W + 5;            // aligned field plus carry
   localparam int LZC_W = $clog2(FW + 1);
   localparam int XW    = EXP_W + LZC_W + 1;    // signed exponent headroom for normalisation
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic signed [XW-1:0] EXP_OVF = XW'((2 ** EXP_W) - 1);

   logic en;

   assign in_ready = !(out_valid & !out_ready);
   assign en       = in_ready;

   // ---------------- Stage 1: unpack, compare, align ----------------
   logic             sign_a, sign_b;
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] frac_a, frac_b, frac_a_f, frac_b_f;
   logic             zero_a, zero_b, nan_a, nan_b, inf_a, inf_b;
   logic             a_ge_b;
   logic             sign_big, zero_big, zero_small;
   logic [EXP_W-1:0] exp_big, exp_small, shift_amt;
   logic [MAN_W-1:0] frac_big, frac_small;
   logic [FW-1:0]    man_big_field, man_small_field, shifted, low_mask, aligned;
   logic             lost;
   logic             is_special, is_invalid;
   logic [W-1:0]     special_sum;

   assign sign_a   = a[W-1];
   assign sign_b   = b[W-1] ^ sub;
   assign exp_a    = a[W-2:MAN_W];
   assign exp_b    = b[W-2:MAN_W];
   assign frac_a   = a[MAN_W-1:0];
   assign frac_b   = b[MAN_W-1:0];
   assign zero_a   = (exp_a == '0);
   assign zero_b   = (exp_b == '0);
   // Subnormals are flushed: their fraction is ignored entirely
   assign frac_a_f = zero_a ? '0 : frac_a;
   assign frac_b_f = zero_b ? '0 : frac_b;
   assign nan_a    = (exp_a == EXP_ONES) && (frac_a != '0);
   assign nan_b    = (exp_b == EXP_ONES) && (frac_b != '0);
   assign inf_a    = (exp_a == EXP_ONES) && (frac_a == '0);
   assign inf_b    = (exp_b == EXP_ONES) && (frac_b == '0);
   assign a_ge_b   = {exp_a, frac_a_f} >= {exp_b, frac_b_f};

   always_comb begin
      sign_big   = sign_b;
      exp_big    = exp_b;
      exp_small  = exp_a;
      frac_big   = frac_b_f;
      frac_small = frac_a_f;
      zero_big   = zero_b;
      zero_small = zero_a;
      if (a_ge_b) begin
         sign_big   = sign_a;
         exp_big    = exp_a;
         exp_small  = exp_b;
         frac_big   = frac_a_f;
         frac_small = frac_b_f;
         zero_big   = zero_a;
         zero_small = zero_b;
      end
   end

   assign man_big_field   = {~zero_big, frac_big, 3'b000};
   assign man_small_field = {~zero_small, frac_small, 3'b000};
   assign shift_amt       = exp_big - exp_small;
   assign shifted         = man_small_field >> shift_amt;

   genvar gi;
   generate
      for (gi = 0; gi < FW; gi++) begin : g_mask
         assign low_mask[gi] = int'(shift_amt) > gi;
      end
   endgenerate

   // Large shifts empty the field naturally; everything shifted out lands in sticky
   assign lost    = |(man_small_field & low_mask);
   assign aligned = {shifted[FW-1:1], shifted[0] | lost};

   assign is_special  = nan_a | nan_b | inf_a | inf_b;
   assign is_invalid  = nan_a | nan_b | (inf_a & inf_b & (sign_a ^ sign_b));
   assign special_sum = is_invalid ? QNAN
                      : {(inf_a ? sign_a : sign_b), EXP_ONES, {MAN_W{1'b0}}};

   logic             s1_valid_reg;
   logic             s1_special_reg, s1_invalid_reg;
   logic [W-1:0]     s1_special_sum_reg;
   logic             s1_sign_reg, s1_eff_sub_reg;
   logic [EXP_W-1:0] s1_exp_reg;
   logic [FW-1:0]    s1_man_big_reg, s1_man_small_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
      end else if (en) begin
         s1_valid_reg       <= in_valid;
         s1_special_reg     <= is_special;
         s1_invalid_reg     <= is_invalid;
         s1_special_sum_reg <= special_sum;
         s1_sign_reg        <= sign_big;
         s1_eff_sub_reg     <= sign_a ^ sign_b;
         s1_exp_reg         <= exp_big;
         s1_man_big_reg     <= man_big_field;
         s1_man_small_reg   <= aligned;
      end
   end

   // ---------------- Stage 2: add/subtract ----------------
   logic [SW-1:0] man_sum;

   // Operands are ordered by magnitude, so the difference never goes negative
   assign man_sum = s1_eff_sub_reg ? ({1'b0, s1_man_big_reg} - {1'b0, s1_man_small_reg})
                                   : ({1'b0, s1_man_big_reg} + {1'b0, s1_man_small_reg});

   logic             s2_valid_reg;
   logic             s2_special_reg, s2_invalid_reg;
   logic [W-1:0]     s2_special_sum_reg;
   logic             s2_sign_reg, s2_eff_sub_reg;
   logic [EXP_W-1:0] s2_exp_reg;
   logic [SW-1:0]    s2_sum_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
      end else if (en) begin
         s2_valid_reg       <= s1_valid_reg;
         s2_special_reg     <= s1_special_reg;
         s2_invalid_reg     <= s1_invalid_reg;
         s2_special_sum_reg <= s1_special_sum_reg;
         s2_sign_reg        <= s1_sign_reg;
         s2_eff_sub_reg     <= s1_eff_sub_reg;
         s2_exp_reg         <= s1_exp_reg;
         s2_sum_reg         <= man_sum;
      end
   end

   // ---------------- Stage 3: normalise, round, pack ----------------
   logic                 carry;
   logic [LZC_W-1:0]     lzc;
   logic [FW-1:0]        norm;
   logic signed [XW-1:0] exp_ext, lzc_ext, exp_norm, exp_rnd;
   logic [MAN_W:0]       mant;
   logic [MAN_W+1:0]     mant_rnd;
   logic                 grd, rnd, stk, round_up, inexact;
   logic [W-1:0]         sum_next;
   logic [3:0]           flags_next;

   assign carry   = s2_sum_reg[SW-1];
   assign exp_ext = {{(XW-EXP_W){1'b0}}, s2_exp_reg};
   assign lzc_ext = {{(XW-LZC_W){1'b0}}, lzc};

   always_comb begin
      lzc = LZC_W'(FW);
      for (int i = 0; i < FW; i++) begin
         if (s2_sum_reg[i]) lzc = LZC_W'(FW - 1 - i);
      end
   end

   always_comb begin
      if (carry) begin
         norm     = {s2_sum_reg[SW-1:2], s2_sum_reg[1] | s2_sum_reg[0]};
         exp_norm = exp_ext + XW'(1);
      end else begin
         norm     = s2_sum_reg[FW-1:0] << lzc;
         exp_norm = exp_ext - lzc_ext;
      end
   end

   assign mant    = norm[FW-1:3];
   assign grd     = norm[2];
   assign rnd     = norm[1];
   assign stk     = norm[0];
   assign inexact = grd | rnd | stk;

`ifdef FP_ADD_RNE_EN
   assign round_up = grd & (rnd | stk | mant[0]);
`else
   assign round_up = 1'b0;
`endif

   // A rounding carry leaves the fraction all zero, so the low bits are correct either way
   assign mant_rnd = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
   assign exp_rnd  = exp_norm + {{(XW-1){1'b0}}, mant_rnd[MAN_W+1]};

   always_comb begin
      sum_next   = {s2_sign_reg, exp_rnd[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
      flags_next = {3'b000, inexact};
      if (s2_special_reg) begin
         sum_next   = s2_special_sum_reg;
         flags_next = {s2_invalid_reg, 3'b000};
      end else if (s2_sum_reg == '0) begin
         // Exact cancellation yields +0; like-signed zeros keep their sign
         sum_next   = {s2_sign_reg & ~s2_eff_sub_reg, {(W-1){1'b0}}};
         flags_next = 4'b0000;
      end else if (exp_rnd >= EXP_OVF) begin
`ifdef FP_ADD_RNE_EN
         sum_next   = {s2_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
`else
         sum_next   = {s2_sign_reg, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
`endif
         flags_next = 4'b0101;
      end else if (exp_rnd[XW-1] || (exp_rnd == '0)) begin
         sum_next   = {s2_sign_reg, {(W-1){1'b0}}};
         flags_next = 4'b0011;
      end
   end

   logic         out_valid_reg;
   logic [W-1:0] sum_reg;
   logic [3:0]   flags_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         sum_reg       <= '0;
         flags_reg     <= '0;
      end else if (en) begin
         out_valid_reg <= s2_valid_reg;
         sum_reg       <= sum_next;
         flags_reg     <= flags_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign sum       = sum_reg;
   assign flags     = flags_reg;

endmodule
